// File: rtl/if_spi_burst.sv
// SPI master bridge: TX FIFO -> shift engine -> RX FIFO, burst framing and sticky overflow flags.
// States: IDLE wait for TX word | LEAD n_cs low, H cycles | SHIFT DATA_W sclk periods | TRAIL n_cs low, H cycles | GAP n_cs high, H cycles

module if_spi_burst_fifo #(
    parameter int W  = 8,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [AW:0]   count,
    output logic          drop
);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;

    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          empty, full, pop_ok, push_ok;

    assign empty   = (count == '0);
    assign full    = count[AW];
    assign pop_ok  = pop & ~empty;
    // a full FIFO still accepts a write when the head leaves in the same cycle
    assign push_ok = push & (~full | pop_ok);
    assign drop    = push & ~push_ok;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push_ok && !pop_ok)      count <= count + CNT_ONE;
            else if (!push_ok && pop_ok) count <= count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end
endmodule

module if_spi_burst #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 5,
    parameter int CLK_DIV    = 8,
    parameter int CPOL       = 0,
    parameter int CPHA       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  n_cs,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_ena,
    output logic                  in_full,
    input  logic                  enc_rdreq,
    output logic [DATA_W-1:0]     out_data,
    output logic                  have_msg,
    output logic [DEPTH_LOG2:0]   len,
    output logic                  ovf_tx,
    output logic                  ovf_rx,
    input  logic                  clr_flags,
    output logic                  busy
);
    localparam int H   = CLK_DIV / 2;
    localparam int DCW = (H > 1) ? $clog2(H) : 1;
    localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [DCW-1:0] H_LAST  = DCW'(H - 1);
    localparam logic [DCW-1:0] DIV_ONE = 1;
    localparam logic [BCW-1:0] B_LAST  = BCW'(DATA_W - 1);
    localparam logic [BCW-1:0] BIT_ONE = 1;
    localparam logic POL = (CPOL != 0);
    localparam logic PHA = (CPHA != 0);

    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

    state_t             state, state_n;
    logic [DCW-1:0]     div_cnt, div_n;
    logic [BCW-1:0]     bit_cnt, bit_n;
    logic               half, half_n;
    logic [DATA_W-1:0]  shreg, shreg_n, rxreg, rxreg_n, rx_word, tx_head;
    logic               n_cs_n, sclk_n, mosi_n;
    logic               tx_pop, rx_push, tx_drop, rx_drop, tx_empty;
    logic [DEPTH_LOG2:0] tx_count;

    if_spi_burst_fifo #(.W(DATA_W), .AW(DEPTH_LOG2)) u_tx (
        .clk(clk), .rst(rst), .push(in_ena), .wdata(in_data), .pop(tx_pop),
        .head(tx_head), .count(tx_count), .drop(tx_drop)
    );

    if_spi_burst_fifo #(.W(DATA_W), .AW(DEPTH_LOG2)) u_rx (
        .clk(clk), .rst(rst), .push(rx_push), .wdata(rx_word), .pop(enc_rdreq),
        .head(out_data), .count(len), .drop(rx_drop)
    );

    assign tx_empty = (tx_count == '0);
    assign in_full  = tx_count[DEPTH_LOG2];
    assign have_msg = (len != '0);
    assign busy     = (state != IDLE) | ~tx_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            half    <= 1'b0;
            shreg   <= '0;
            rxreg   <= '0;
            n_cs    <= 1'b1;
            sclk    <= POL;
            mosi    <= 1'b0;
            ovf_tx  <= 1'b0;
            ovf_rx  <= 1'b0;
        end else begin
            state   <= state_n;
            div_cnt <= div_n;
            bit_cnt <= bit_n;
            half    <= half_n;
            shreg   <= shreg_n;
            rxreg   <= rxreg_n;
            n_cs    <= n_cs_n;
            sclk    <= sclk_n;
            mosi    <= mosi_n;
            ovf_tx  <= (ovf_tx & ~clr_flags) | tx_drop;
            ovf_rx  <= (ovf_rx & ~clr_flags) | rx_drop;
        end
    end

    always_comb begin
        state_n = state;
        div_n   = div_cnt;
        bit_n   = bit_cnt;
        half_n  = half;
        shreg_n = shreg;
        rxreg_n = rxreg;
        n_cs_n  = n_cs;
        sclk_n  = sclk;
        mosi_n  = mosi;
        tx_pop  = 1'b0;
        rx_push = 1'b0;
        rx_word = rxreg;
        case (state)
            IDLE: begin
                if (!tx_empty) begin
                    tx_pop  = 1'b1;
                    shreg_n = tx_head;
                    n_cs_n  = 1'b0;
                    div_n   = H_LAST;
                    state_n = LEAD;
                    if (!PHA) mosi_n = tx_head[DATA_W-1];
                end
            end
            LEAD: begin
                if (div_cnt == '0) begin
                    div_n   = H_LAST;
                    half_n  = 1'b0;
                    bit_n   = B_LAST;
                    state_n = SHIFT;
                    if (PHA) mosi_n = shreg[DATA_W-1];
                end else begin
                    div_n = div_cnt - DIV_ONE;
                end
            end
            SHIFT: begin
                if (div_cnt != '0) begin
                    div_n = div_cnt - DIV_ONE;
                end else if (!half) begin
                    div_n  = H_LAST;
                    half_n = 1'b1;
                    sclk_n = ~POL;
                    if (!PHA) rxreg_n = {rxreg[DATA_W-2:0], miso};
                end else begin
                    div_n   = H_LAST;
                    half_n  = 1'b0;
                    sclk_n  = POL;
                    // with CPHA=1 the final bit is sampled on this same edge
                    rx_word = PHA ? {rxreg[DATA_W-2:0], miso} : rxreg;
                    rxreg_n = rx_word;
                    if (bit_cnt != '0) begin
                        bit_n   = bit_cnt - BIT_ONE;
                        shreg_n = shreg << 1;
                        mosi_n  = shreg[DATA_W-2];
                    end else begin
                        rx_push = 1'b1;
                        if (!tx_empty) begin
                            tx_pop  = 1'b1;
                            shreg_n = tx_head;
                            mosi_n  = tx_head[DATA_W-1];
                            bit_n   = B_LAST;
                        end else begin
                            state_n = TRAIL;
                        end
                    end
                end
            end
            TRAIL: begin
                if (div_cnt == '0) begin
                    n_cs_n  = 1'b1;
                    div_n   = H_LAST;
                    state_n = GAP;
                end else begin
                    div_n = div_cnt - DIV_ONE;
                end
            end
            GAP: begin
                if (div_cnt == '0) state_n = IDLE;
                else               div_n   = div_cnt - DIV_ONE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_if_spi_burst.sv
// Bench for if_spi_burst: default-parameter instance with mosi looped to miso, plus four
// DATA_W=16 instances (one per CPOL/CPHA) each talking to a behavioural SPI slave.
module tb_if_spi_burst;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ecount = 0;

    logic       n_cs, sclk, mosi, miso, in_ena, in_full, enc_rdreq, have_msg;
    logic       ovf_tx, ovf_rx, clr_flags, busy;
    logic [7:0] in_data, out_data;
    logic [5:0] len;

    assign miso = mosi;

    if_spi_burst dut (
        .clk(clk), .rst(rst), .n_cs(n_cs), .sclk(sclk), .mosi(mosi), .miso(miso),
        .in_data(in_data), .in_ena(in_ena), .in_full(in_full), .enc_rdreq(enc_rdreq),
        .out_data(out_data), .have_msg(have_msg), .len(len), .ovf_tx(ovf_tx),
        .ovf_rx(ovf_rx), .clr_flags(clr_flags), .busy(busy)
    );

    // frame monitor for the default instance
    int          low_cnt = 0, rise_cnt = 0, win_cnt = 0;
    logic [31:0] mword = '0;
    logic        mon_ncs = 1'b1, mon_sclk = 1'b0;
    always @(negedge clk) begin
        if (n_cs === 1'b0) begin
            low_cnt++;
            if (mon_ncs) win_cnt++;
            if (sclk && !mon_sclk) begin
                rise_cnt++;
                mword = {mword[30:0], mosi};
            end
        end
        mon_ncs  = n_cs;
        mon_sclk = sclk;
    end

    logic [3:0]  m_ncs, m_sclk, m_mosi, m_miso, m_full, m_have, m_otx, m_orx, m_busy;
    logic [63:0] m_out, s_word, s_rx;
    logic [11:0] m_len;
    logic [15:0] m_data;
    logic        m_ena, m_rd;

    for (genvar g = 0; g < 4; g++) begin : g_mode
        localparam logic POL = ((g / 2) != 0);
        localparam logic PHA = ((g % 2) != 0);
        logic [15:0] sw;
        logic [15:0] srx = '0;
        logic        miso_r = 1'b0, p_ncs = 1'b1, p_sclk = POL, p_mosi = 1'b0;
        int          sbit = 0;

        assign sw = s_word[g*16 +: 16];
        assign s_rx[g*16 +: 16] = srx;
        assign m_miso[g] = miso_r;

        if_spi_burst #(.DATA_W(16), .DEPTH_LOG2(2), .CLK_DIV(4), .CPOL(g / 2), .CPHA(g % 2)) u_dut (
            .clk(clk), .rst(rst), .n_cs(m_ncs[g]), .sclk(m_sclk[g]), .mosi(m_mosi[g]),
            .miso(m_miso[g]), .in_data(m_data), .in_ena(m_ena), .in_full(m_full[g]),
            .enc_rdreq(m_rd), .out_data(m_out[g*16 +: 16]), .have_msg(m_have[g]),
            .len(m_len[g*3 +: 3]), .ovf_tx(m_otx[g]), .ovf_rx(m_orx[g]),
            .clr_flags(1'b0), .busy(m_busy[g])
        );

        // slave: CPHA=0 drives on cs fall / trailing edges and samples on leading edges,
        // CPHA=1 drives on leading edges and samples on trailing edges
        always @(negedge clk) begin
            if (m_ncs[g] === 1'b0) begin
                if (p_ncs) begin
                    sbit = 0;
                    srx  = '0;
                    if (!PHA) miso_r = sw[15];
                end else if (m_sclk[g] != p_sclk) begin
                    if (m_sclk[g] != POL) begin
                        if (!PHA) srx = {srx[14:0], p_mosi};
                        else begin
                            miso_r = sw[15 - sbit];
                            sbit++;
                        end
                    end else begin
                        if (!PHA) begin
                            sbit++;
                            if (sbit < 16) miso_r = sw[15 - sbit];
                        end else begin
                            srx = {srx[14:0], p_mosi};
                        end
                    end
                end
            end
            p_ncs  = m_ncs[g];
            p_sclk = m_sclk[g];
            p_mosi = m_mosi[g];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        ecount++;
    endtask

    task automatic run_to(input int e);
        while (ecount < e) step();
    endtask

    task automatic write_word(input logic [7:0] w);
        in_data = w;
        in_ena  = 1'b1;
        step();
        in_ena  = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while ((busy !== 1'b0 || m_busy !== 4'b0) && n < maxc) begin
            step();
            n++;
        end
        chk("idle_timeout", 64'(busy | (|m_busy)), 64'd0);
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk(tag, 64'(out_data), 64'(exp));
        enc_rdreq = 1'b1;
        step();
        enc_rdreq = 1'b0;
    endtask

    logic [7:0]  w;
    logic [7:0]  sent[$];
    logic [7:0]  rxq[$];
    logic [15:0] tw;
    int          lc0, rc0, wc0, nb;

    initial begin
        in_ena = 0; in_data = 0; enc_rdreq = 0; clr_flags = 0;
        m_ena = 0; m_rd = 0; m_data = 0; s_word = 0;
        repeat (3) step();
        rst = 1'b0;
        step();

        chk("rst_ncs", 64'(n_cs), 64'd1);
        chk("rst_sclk", 64'(sclk), 64'd0);
        chk("rst_mosi", 64'(mosi), 64'd0);
        chk("rst_have", 64'(have_msg), 64'd0);
        chk("rst_len", 64'(len), 64'd0);
        chk("rst_full", 64'(in_full), 64'd0);
        chk("rst_flags", 64'({ovf_tx, ovf_rx}), 64'd0);
        chk("rst_out", 64'(out_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mode_sclk", 64'(m_sclk), 64'(4'b1100));
        chk("rst_mode_ncs", 64'(m_ncs), 64'(4'b1111));

        // single word 0xA5: 72-cycle frame, 8 rising edges, have_msg one cycle after push
        lc0 = low_cnt; rc0 = rise_cnt; wc0 = win_cnt;
        ecount = -1;
        write_word(8'hA5);
        run_to(68);
        chk("have_before_push", 64'(have_msg), 64'd0);
        step();
        chk("have_after_push", 64'(have_msg), 64'd1);
        wait_idle(300);
        chk("a5_ncs_low", 64'(low_cnt - lc0), 64'd72);
        chk("a5_sclk_rises", 64'(rise_cnt - rc0), 64'd8);
        chk("a5_windows", 64'(win_cnt - wc0), 64'd1);
        chk("a5_mosi_seq", 64'(mword[7:0]), 64'hA5);
        chk("a5_len", 64'(len), 64'd1);
        chk("a5_out", 64'(out_data), 64'hA5);

        // reset in the middle of SHIFT
        write_word(8'($urandom));
        repeat (20) step();
        #2 rst = 1'b1;
        #1;
        chk("midrst_ncs", 64'(n_cs), 64'd1);
        chk("midrst_sclk", 64'(sclk), 64'd0);
        chk("midrst_len", 64'(len), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_have", 64'(have_msg), 64'd0);
        step();
        rst = 1'b0;
        step();
        w = 8'($urandom);
        write_word(w);
        wait_idle(300);
        chk("postrst_len", 64'(len), 64'd1);
        pop_chk("postrst_word", w);
        chk("postrst_empty", 64'({have_msg, len}), 64'd0);
        chk("postrst_out_zero", 64'(out_data), 64'd0);

        // three back-to-back words form one 200-cycle window
        lc0 = low_cnt; wc0 = win_cnt;
        write_word(8'h01);
        write_word(8'h02);
        write_word(8'h03);
        wait_idle(400);
        chk("b3_ncs_low", 64'(low_cnt - lc0), 64'd200);
        chk("b3_windows", 64'(win_cnt - wc0), 64'd1);
        chk("b3_len", 64'(len), 64'd3);
        pop_chk("b3_w0", 8'h01);
        pop_chk("b3_w1", 8'h02);
        pop_chk("b3_w2", 8'h03);

        // random burst of random words against the framing formula
        nb = $urandom_range(6, 2);
        rxq.delete();
        lc0 = low_cnt; wc0 = win_cnt;
        for (int i = 0; i < nb; i++) begin
            w = 8'($urandom);
            rxq.push_back(w);
            write_word(w);
        end
        wait_idle(800);
        chk("rb_ncs_low", 64'(low_cnt - lc0), 64'((2 * 8 * nb + 2) * 4));
        chk("rb_windows", 64'(win_cnt - wc0), 64'd1);
        chk("rb_len", 64'(len), 64'(nb));
        while (rxq.size() > 0) pop_chk("rb_word", rxq.pop_front());

        // overflow: fill TX while the first word is shifting, then overrun RX
        sent.delete();
        rxq.delete();
        lc0 = low_cnt; wc0 = win_cnt;
        ecount = -1;
        w = 8'($urandom); sent.push_back(w); write_word(w);
        run_to(10);
        for (int i = 0; i < 32; i++) begin
            w = 8'($urandom); sent.push_back(w); write_word(w);
        end
        chk("tx_full", 64'(in_full), 64'd1);
        chk("tx_no_ovf_yet", 64'(ovf_tx), 64'd0);
        write_word(8'($urandom));
        chk("ovf_tx_set", 64'(ovf_tx), 64'd1);
        chk("tx_still_full", 64'(in_full), 64'd1);
        in_data = 8'($urandom); in_ena = 1'b1; clr_flags = 1'b1;
        step();
        in_ena = 1'b0;
        chk("ovf_tx_clr_vs_new", 64'(ovf_tx), 64'd1);
        step();
        clr_flags = 1'b0;
        chk("ovf_tx_cleared", 64'(ovf_tx), 64'd0);
        run_to(68);
        w = 8'($urandom); sent.push_back(w); write_word(w);
        chk("full_pop_write_full", 64'(in_full), 64'd1);
        chk("full_pop_write_no_ovf", 64'(ovf_tx), 64'd0);
        for (int i = 0; i < 32; i++) rxq.push_back(sent[i]);
        run_to(2116);
        chk("rx_full_len", 64'(len), 64'd32);
        chk("rx_no_ovf_yet", 64'(ovf_rx), 64'd0);
        enc_rdreq = 1'b1;
        step();
        enc_rdreq = 1'b0;
        void'(rxq.pop_front());
        rxq.push_back(sent[32]);
        chk("rx_pop_push_len", 64'(len), 64'd32);
        chk("rx_pop_push_no_ovf", 64'(ovf_rx), 64'd0);
        chk("rx_pop_push_head", 64'(out_data), 64'(rxq[0]));
        wait_idle(400);
        chk("ovf_rx_set", 64'(ovf_rx), 64'd1);
        chk("ovf_rx_len", 64'(len), 64'd32);
        chk("ovf_ncs_low", 64'(low_cnt - lc0), 64'((2 * 8 * 34 + 2) * 4));
        chk("ovf_windows", 64'(win_cnt - wc0), 64'd1);
        while (rxq.size() > 0) pop_chk("ovf_drain", rxq.pop_front());
        chk("ovf_drained", 64'(len), 64'd0);
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        chk("flags_cleared", 64'({ovf_tx, ovf_rx}), 64'd0);

        // the four SPI modes against the slave model
        for (int r = 0; r < 2; r++) begin
            tw = (r == 0) ? 16'h8001 : 16'($urandom);
            s_word = {32'($urandom), 32'($urandom)};
            m_data = tw;
            m_ena  = 1'b1;
            step();
            m_ena  = 1'b0;
            wait_idle(300);
            for (int g = 0; g < 4; g++) begin
                chk($sformatf("mode%0d_rx_word", g), 64'(m_out[g*16 +: 16]), 64'(s_word[g*16 +: 16]));
                chk($sformatf("mode%0d_slave_got", g), 64'(s_rx[g*16 +: 16]), 64'(tw));
                chk($sformatf("mode%0d_len", g), 64'(m_len[g*3 +: 3]), 64'd1);
                chk($sformatf("mode%0d_idle_sclk", g), 64'(m_sclk[g]), 64'(g / 2));
            end
            m_rd = 1'b1;
            step();
            m_rd = 1'b0;
            chk("mode_drained", 64'(m_have), 64'd0);
        end
        chk("mode_flags", 64'({m_full, m_otx, m_orx}), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
